rs232_rx_fifo: RTL and testbench

//  Byte FIFO directly downstream of the RS232 receiver. The receiver emits single-cycle

---
 rtl/rs232_rx_fifo.sv | 100 ++++++++++
 tb/tb_rs232_rx_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rs232_rx_fifo.sv
// Receive-side byte FIFO behind the RS232 receiver: first-word-fall-through storage,
// CTS flow control with hysteresis and a sticky overflow flag.
module rs232_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned HIGH_WATER = 12,
  parameter int unsigned LOW_WATER  = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  rs232_ctsn,
  output logic                  overflow,
  input  logic                  clear_overflow,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;

  if (!((LOW_WATER < HIGH_WATER) && (HIGH_WATER <= DEPTH))) begin : g_bad_params
    $error("rs232_rx_fifo: watermarks must satisfy LOW_WATER < HIGH_WATER <= 2**DEPTH_LOG2");
  end

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic [LW-1:0] level_next;

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  always_comb begin
    full       = (level == LW'(DEPTH));
    pop        = out_valid && out_ready;
    push       = in_valid && (!full || pop);
    drop       = in_valid && full && !pop;
    level_next = level;
    if (push && !pop) begin
      level_next = level + LW'(1);
    end else if (pop && !push) begin
      level_next = level - LW'(1);
    end
  end

  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];

  // Storage is intentionally not reset; contents are qualified by level.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      level  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      level <= level_next;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Set beats clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Hysteresis on the post-update level; between the marks the previous state holds.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rs232_ctsn <= 1'b1;
    end else if (level_next >= LW'(HIGH_WATER)) begin
      rs232_ctsn <= 1'b1;
    end else if (level_next <= LW'(LOW_WATER)) begin
      rs232_ctsn <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Directed bench for rs232_rx_fifo: ordering, watermarks, overflow and async reset.
module tb_rs232_rx_fifo;

  logic       clock;
  logic       resetn;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       rs232_ctsn;
  logic       overflow;
  logic       clear_overflow;
  logic [4:0] level;

  int vectors = 0;
  int errors  = 0;

  rs232_rx_fifo dut (
    .clock          (clock),
    .resetn         (resetn),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .rs232_ctsn     (rs232_ctsn),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .level          (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    resetn         = 1'b0;
    in_data        = 8'h00;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    clear_overflow = 1'b0;

    // 1: reset values, then idle after release
    tick();
    tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ctsn", 32'(rs232_ctsn), 32'd1);
    check("rst_ovf", 32'(overflow), 32'd0);
    resetn = 1'b1;
    tick();
    tick();
    check("idle_level", 32'(level), 32'd0);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_ctsn", 32'(rs232_ctsn), 32'd0);
    check("idle_ovf", 32'(overflow), 32'd0);

    // 2: three bytes, fall-through latency, in-order drain
    push_byte(8'h41);
    check("ft_valid", 32'(out_valid), 32'd1);
    check("ft_data", 32'(out_data), 32'h41);
    check("ft_level1", 32'(level), 32'd1);
    push_byte(8'h42);
    push_byte(8'h43);
    check("ft_level3", 32'(level), 32'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ft_pop", 32'(out_data), 32'h41 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("ft_level0", 32'(level), 32'd0);
    check("ft_empty", 32'(out_valid), 32'd0);

    // 3: watermark hysteresis
    for (int i = 0; i < 11; i++) push_byte(8'h10 + 8'(i));
    check("hw_lvl11", 32'(level), 32'd11);
    check("hw_cts11", 32'(rs232_ctsn), 32'd0);
    push_byte(8'h1B);
    check("hw_lvl12", 32'(level), 32'd12);
    check("hw_cts12", 32'(rs232_ctsn), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("hw_pop", 32'(out_data), 32'h10 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("hw_lvl9", 32'(level), 32'd9);
    check("hw_cts9", 32'(rs232_ctsn), 32'd1);
    out_ready = 1'b1;
    check("hw_pop", 32'(out_data), 32'h13);
    tick();
    out_ready = 1'b0;
    check("hw_lvl8", 32'(level), 32'd8);
    check("hw_cts8", 32'(rs232_ctsn), 32'd0);
    out_ready = 1'b1;
    for (int i = 4; i < 12; i++) begin
      check("hw_drain", 32'(out_data), 32'h10 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("hw_empty", 32'(level), 32'd0);

    // 4: overflow on full, clear, and set-wins-over-clear
    for (int i = 0; i < 16; i++) push_byte(8'h60 + 8'(i));
    check("of_full", 32'(level), 32'd16);
    check("of_ovf0", 32'(overflow), 32'd0);
    check("of_cts", 32'(rs232_ctsn), 32'd1);
    push_byte(8'hEE);
    check("of_ovf1", 32'(overflow), 32'd1);
    check("of_level", 32'(level), 32'd16);
    check("of_head", 32'(out_data), 32'h60);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("of_clr", 32'(overflow), 32'd0);
    clear_overflow = 1'b1;
    push_byte(8'hEF);
    clear_overflow = 1'b0;
    check("of_setwins", 32'(overflow), 32'd1);
    check("of_level2", 32'(level), 32'd16);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("of_clr2", 32'(overflow), 32'd0);

    // 5: full with simultaneous push and pop
    in_data   = 8'h55;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check("fp_head", 32'(out_data), 32'h60);
    tick();
    in_valid = 1'b0;
    check("fp_ovf", 32'(overflow), 32'd0);
    check("fp_level", 32'(level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("fp_drain", 32'(out_data), (i < 15) ? 32'h61 + 32'(i) : 32'h55);
      tick();
    end
    out_ready = 1'b0;
    check("fp_empty", 32'(out_valid), 32'd0);
    check("fp_level0", 32'(level), 32'd0);
    check("fp_cts", 32'(rs232_ctsn), 32'd0);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
    check("ar_lvl5", 32'(level), 32'd5);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_level", 32'(level), 32'd0);
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_ctsn", 32'(rs232_ctsn), 32'd1);
    check("ar_ovf", 32'(overflow), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    check("ar_rel_ctsn", 32'(rs232_ctsn), 32'd0);
    check("ar_rel_level", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
